aig_resp_misr: RTL

- Sequential response compactor placed directly downstream of a 4-input/15-output combinational benchmark netlist (outputs f1..f15).
- Accepts one 15-bit response vector per handshake and folds it into a multiple-input signature register (MISR).
- After a programmed number of vectors, it compares the signature against a golden value and reports pass/fail.
- Lets a bench or BIST wrapper check a synthesized variant (e.g. a resyn2 netlist) against its golden signature without storing every output vector.

---
 rtl/aig_bist_pkg.sv | 26 ++
 rtl/misr_core.sv | 40 ++++
 rtl/aig_resp_misr.sv | 105 ++++++++++
 3 files changed

// File: rtl/aig_bist_pkg.sv
// Shared types and helpers for the AIG BIST response path: FSM state
// encoding, default MISR taps/seed, and the single-step MISR update used by
// the upstream pattern source and by models.
package aig_bist_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } misr_state_e;

  localparam int unsigned MisrWidth = 15;

  // x^15 + x + 1; the x^15 term is implicit
  localparam logic [MisrWidth-1:0] DefaultPoly = 15'h0003;
  localparam logic [MisrWidth-1:0] DefaultSeed = 15'h0000;

  // One Galois MISR step: shift left, fold the dropped MSB back through the
  // taps, then XOR in the response vector.
  function automatic logic [MisrWidth-1:0] misr_next(input logic [MisrWidth-1:0] sig,
                                                     input logic [MisrWidth-1:0] resp,
                                                     input logic [MisrWidth-1:0] poly);
    return {sig[MisrWidth-2:0], 1'b0} ^ (sig[MisrWidth-1] ? poly : '0) ^ resp;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with Galois MISR next-state logic. load (re)seeds the
// register, en folds one response vector in. sig_next exposes the value the
// register would take on an enabled edge so the controller can compare the
// final signature in the same cycle it is produced.
module misr_core
  import aig_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = MisrWidth,
  parameter logic [WIDTH-1:0] POLY  = DefaultPoly
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  logic [WIDTH-1:0] sig_q;

  // Shift, conditional tap feedback, XOR in the response.
  always_comb begin
    sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp;
  end

  // Signature register; resp only reaches sig_q through en, so an X on an
  // idle bus never lands in the signature.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig_q <= seed;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/aig_resp_misr.sv
// Response compactor: folds NPAT handshaked response vectors into a MISR and
// reports whether the final signature matches the supplied golden value.
module aig_resp_misr
  import aig_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = MisrWidth,
  parameter logic [WIDTH-1:0] POLY  = DefaultPoly,
  parameter logic [WIDTH-1:0] SEED  = DefaultSeed,
  parameter int unsigned      NPAT  = 16,
  parameter int unsigned      CW    = $clog2(NPAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_resp,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] sig,
  output logic [CW-1:0]    pat_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  misr_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] sig_next;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (accept),
    .seed     (SEED),
    .resp     (in_resp),
    .sig      (sig),
    .sig_next (sig_next)
  );

  // Next-state, counter and verdict logic; start is only honoured outside RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    load     = 1'b0;
    in_ready = (state_q == StRun);
    accept   = in_valid & in_ready;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          // Last vector: the verdict uses the signature this accept produces.
          if (cnt_q == CW'(NPAT - 1)) begin
            state_d = StDone;
            pass_d  = (sig_next == golden);
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          pass_d  = 1'b0;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, pattern counter and registered verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign pat_cnt = cnt_q;
  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign pass    = pass_q;

endmodule
